beat_scheduler: RTL

Metronome beat scheduler: consumes validated period updates from the UART BPM receiver and drives the beat/accent pulse train for the output stage. It holds a pending period in a shadow register and applies it only on a beat boundary, so tempo changes never produce a short or long beat. It sits between the UART BPM receiver and the click/LED output logic.

---
 rtl/metronome_pkg.sv | 25 ++
 rtl/beat_scheduler_if.sv | 28 ++
 rtl/beat_period_counter.sv | 44 ++++
 rtl/beat_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/metronome_pkg.sv
// Shared metronome definitions: scheduler state encoding, default limits and
// the period width also used by the UART BPM receiver.
package metronome_pkg;

  localparam int PERIOD_W = 32;
  localparam logic [PERIOD_W-1:0] MIN_PERIOD_DEFAULT = 32'd1000;
  localparam int BEATS_PER_BAR_DEFAULT = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Beat index advance with wrap at the last beat of the bar.
  function automatic logic [7:0] next_beat_index(input logic [7:0] idx, input logic [7:0] last_idx);
    logic [7:0] nxt;
    if (idx >= last_idx) begin
      nxt = 8'd0;
    end else begin
      nxt = idx + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/beat_scheduler_if.sv
// Config and beat-train signals between the BPM receiver, the scheduler and
// the click/LED output stage.
interface beat_scheduler_if
  import metronome_pkg::*;
();

  logic                i_cfg_valid;
  logic [PERIOD_W-1:0] i_cfg_period;
  logic                i_enable;
  logic                o_beat;
  logic                o_accent;
  logic [7:0]          o_beat_index;
  logic [PERIOD_W-1:0] o_period;
  logic                o_pending;
  logic                o_cfg_err;
  logic                o_running;

  modport slave (
    input  i_cfg_valid, i_cfg_period, i_enable,
    output o_beat, o_accent, o_beat_index, o_period, o_pending, o_cfg_err, o_running
  );

  modport master (
    output i_cfg_valid, i_cfg_period, i_enable,
    input  o_beat, o_accent, o_beat_index, o_period, o_pending, o_cfg_err, o_running
  );

endinterface

// File: rtl/beat_period_counter.sv
// Free-running clocks-per-beat counter; o_wrap flags the last clock of a beat
// so the scheduler can register the beat pulse on that edge.
module beat_period_counter
  import metronome_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_wrap
);

  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] count_d;
  logic                wrap_s;

  assign wrap_s = i_enable && !i_clear && (count_q == (i_period - 32'd1));
  assign o_wrap = wrap_s;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      if (wrap_s) begin
        count_d = '0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/beat_scheduler.sv
// Metronome beat scheduler: shadows validated period requests and applies them
// only on beat boundaries so no beat is ever shortened or stretched.
module beat_scheduler
  import metronome_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] MIN_PERIOD    = MIN_PERIOD_DEFAULT,
  parameter int                  BEATS_PER_BAR = BEATS_PER_BAR_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  beat_scheduler_if.slave   bus
);

  localparam logic [7:0] LAST_IDX = 8'(BEATS_PER_BAR - 1);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] active_q, active_d;
  logic [PERIOD_W-1:0] pend_val_q, pend_val_d;
  logic                pend_q, pend_d;
  logic [7:0]          index_q, index_d;
  logic                beat_q, beat_d;
  logic                accent_q, accent_d;
  logic                cfg_err_q, cfg_err_d;
  logic                running_q, running_d;

  logic                cnt_clear_s;
  logic                wrap_s;
  logic [7:0]          next_idx_s;

  // The counter only runs while RUN is held; leaving or entering RUN restarts it.
  assign cnt_clear_s = (state_q != ST_RUN) || !bus.i_enable;
  assign next_idx_s  = next_beat_index(index_q, LAST_IDX);

  beat_period_counter u_counter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (cnt_clear_s),
    .i_enable  (1'b1),
    .i_period  (active_q),
    .o_wrap    (wrap_s)
  );

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    index_d    = index_q;
    beat_d     = 1'b0;
    accent_d   = 1'b0;
    cfg_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_enable && (pend_q || (active_q != 32'd0))) begin
          state_d  = ST_RUN;
          index_d  = 8'd0;
          beat_d   = 1'b1;
          accent_d = 1'b1;
          if (pend_q) begin
            active_d = pend_val_q;
            pend_d   = 1'b0;
          end else begin
            active_d = active_q;
          end
        end else begin
          index_d = 8'd0;
        end
      end
      ST_RUN: begin
        if (!bus.i_enable) begin
          state_d = ST_IDLE;
          index_d = 8'd0;
        end else if (wrap_s) begin
          index_d  = next_idx_s;
          beat_d   = 1'b1;
          accent_d = (next_idx_s == 8'd0);
          if (pend_q) begin
            active_d = pend_val_q;
            pend_d   = 1'b0;
          end else begin
            active_d = active_q;
          end
        end else begin
          index_d = index_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        index_d = 8'd0;
      end
    endcase

    // A request arriving on a boundary edge is applied after the one consumed there.
    if (bus.i_cfg_valid) begin
      if (bus.i_cfg_period >= MIN_PERIOD) begin
        pend_val_d = bus.i_cfg_period;
        pend_d     = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = 1'b0;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      active_q   <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      index_q    <= 8'd0;
      beat_q     <= 1'b0;
      accent_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      index_q    <= index_d;
      beat_q     <= beat_d;
      accent_q   <= accent_d;
      cfg_err_q  <= cfg_err_d;
      running_q  <= running_d;
    end
  end

  assign bus.o_beat       = beat_q;
  assign bus.o_accent     = accent_q;
  assign bus.o_beat_index = index_q;
  assign bus.o_period     = active_q;
  assign bus.o_pending    = pend_q;
  assign bus.o_cfg_err    = cfg_err_q;
  assign bus.o_running    = running_q;

endmodule
